// File: rtl/sram_ctrl.sv
// Single-port SRAM initiator: takes word read/write requests on a valid/ready port,
// issues one-cycle SRAM strobes and returns read data after a fixed wait.
module sram_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_wen,
  output logic              sram_sense_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int CNT_W = $clog2(RD_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
  logic              wen_next, sense_en_next, rsp_valid_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] din_next, rdata_next;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      sram_wen      <= 1'b0;
      sram_sense_en <= 1'b0;
      sram_addr     <= '0;
      sram_din      <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state         <= state_next;
      wait_cnt      <= wait_cnt_next;
      sram_wen      <= wen_next;
      sram_sense_en <= sense_en_next;
      sram_addr     <= addr_next;
      sram_din      <= din_next;
      rsp_valid     <= rsp_valid_next;
      rsp_rdata     <= rdata_next;
    end
  end

  // Strobes default low so each one lasts exactly the cycle after its set edge.
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    wen_next       = 1'b0;
    sense_en_next  = 1'b0;
    addr_next      = sram_addr;
    din_next       = sram_din;
    rsp_valid_next = rsp_valid;
    rdata_next     = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_next = req_addr;
          if (req_we) begin
            din_next   = req_wdata;
            wen_next   = 1'b1;
            state_next = WR;
          end else begin
            sense_en_next = 1'b1;
            state_next    = RD;
          end
        end
      end
      WR: state_next = IDLE;
      RD: begin
        wait_cnt_next = CNT_LOAD;
        state_next    = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          rdata_next     = sram_dout;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          wait_cnt_next = wait_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Drives three controllers (RD_WAIT = 1, 2, 4) against a behavioural SRAM and a
// reference memory, checking strobes, latency, response holding and reset.
module tb_sram_ctrl;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n         [NI];
  logic       req_valid     [NI];
  logic       req_ready     [NI];
  logic       req_we        [NI];
  logic [9:0] req_addr      [NI];
  logic [7:0] req_wdata     [NI];
  logic       rsp_valid     [NI];
  logic       rsp_ready     [NI];
  logic [7:0] rsp_rdata     [NI];
  logic       sram_wen      [NI];
  logic       sram_sense_en [NI];
  logic [9:0] sram_addr     [NI];
  logic [7:0] sram_din      [NI];
  logic [7:0] sram_dout     [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      sram_ctrl #(
        .ADDR_W (10),
        .DATA_W (8),
        .RD_WAIT(gi == 0 ? 1 : (gi == 1 ? 2 : 4))
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n[gi]),
        .req_valid    (req_valid[gi]),
        .req_ready    (req_ready[gi]),
        .req_we       (req_we[gi]),
        .req_addr     (req_addr[gi]),
        .req_wdata    (req_wdata[gi]),
        .rsp_valid    (rsp_valid[gi]),
        .rsp_ready    (rsp_ready[gi]),
        .rsp_rdata    (rsp_rdata[gi]),
        .sram_wen     (sram_wen[gi]),
        .sram_sense_en(sram_sense_en[gi]),
        .sram_addr    (sram_addr[gi]),
        .sram_din     (sram_din[gi]),
        .sram_dout    (sram_dout[gi])
      );
    end
  endgenerate

  function automatic int rdw(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Behavioural SRAM macro plus strobe monitors.
  logic [7:0] sram_mem [NI][1024];
  int cyc = 0;
  int wen_cycles   [NI] = '{default: 0};
  int sense_cycles [NI] = '{default: 0};
  int overlap_cyc  [NI] = '{default: 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (sram_wen[k]) sram_mem[k][sram_addr[k]] <= sram_din[k];
      if (sram_sense_en[k]) sram_dout[k] <= sram_mem[k][sram_addr[k]];
      if (sram_wen[k]) wen_cycles[k] <= wen_cycles[k] + 1;
      if (sram_sense_en[k]) sense_cycles[k] <= sense_cycles[k] + 1;
      if (sram_wen[k] && sram_sense_en[k]) overlap_cyc[k] <= overlap_cyc[k] + 1;
    end
  end

  // Reference model: expected memory contents and expected strobe counts.
  logic [7:0] ref_mem [NI][1024];
  int exp_wen   [NI] = '{default: 0};
  int exp_sense [NI] = '{default: 0};
  int acc_cyc   [NI] = '{default: 0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!req_ready[k] && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("req_ready_wait[%0d]", k), 32'(req_ready[k]), 1);
  endtask

  task automatic do_write(input int k, input logic [9:0] a, input logic [7:0] d);
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b1;
    req_addr[k]  = a;
    req_wdata[k] = d;
    wait_ready(k);
    tick();
    acc_cyc[k] = cyc;
    check($sformatf("wr_wen[%0d]", k), 32'(sram_wen[k]), 1);
    check($sformatf("wr_sense[%0d]", k), 32'(sram_sense_en[k]), 0);
    check($sformatf("wr_addr[%0d]", k), 32'(sram_addr[k]), 32'(a));
    check($sformatf("wr_din[%0d]", k), 32'(sram_din[k]), 32'(d));
    check($sformatf("wr_busy[%0d]", k), 32'(req_ready[k]), 0);
    exp_wen[k]++;
    ref_mem[k][a] = d;
    // Keep valid high with changing fields while busy; none of it may be used.
    req_we[k]    = 1'($urandom);
    req_addr[k]  = 10'($urandom);
    req_wdata[k] = 8'($urandom);
    tick();
    check($sformatf("wr_wen_end[%0d]", k), 32'(sram_wen[k]), 0);
    check($sformatf("wr_ready_back[%0d]", k), 32'(req_ready[k]), 1);
    req_valid[k] = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [9:0] a, input int hold);
    int lat = 0;
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = a;
    req_wdata[k] = 8'($urandom);
    wait_ready(k);
    tick();
    check($sformatf("rd_sense[%0d]", k), 32'(sram_sense_en[k]), 1);
    check($sformatf("rd_wen[%0d]", k), 32'(sram_wen[k]), 0);
    check($sformatf("rd_addr[%0d]", k), 32'(sram_addr[k]), 32'(a));
    exp_sense[k]++;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = 10'($urandom);
    req_wdata[k] = 8'($urandom);
    do begin
      tick();
      lat++;
    end while (!rsp_valid[k] && lat < 20);
    check($sformatf("rd_latency[%0d]", k), 32'(lat), 32'(1 + rdw(k)));
    check($sformatf("rd_data[%0d]", k), 32'(rsp_rdata[k]), 32'(ref_mem[k][a]));
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("rsp_hold_valid[%0d]", k), 32'(rsp_valid[k]), 1);
      check($sformatf("rsp_hold_data[%0d]", k), 32'(rsp_rdata[k]), 32'(ref_mem[k][a]));
      check($sformatf("rsp_hold_ready[%0d]", k), 32'(req_ready[k]), 0);
    end
    rsp_ready[k] = 1'b1;
    tick();
    check($sformatf("rsp_drop[%0d]", k), 32'(rsp_valid[k]), 0);
    check($sformatf("rsp_ready_back[%0d]", k), 32'(req_ready[k]), 1);
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
  endtask

  task automatic reset_during_wait(input int k);
    logic [7:0] d;
    logic       seen;
    d = 8'($urandom_range(1, 255));
    do_write(k, 10'h055, d);
    req_valid[k] = 1'b1;
    req_we[k]    = 1'b0;
    req_addr[k]  = 10'h055;
    wait_ready(k);
    tick();
    exp_sense[k]++;
    req_valid[k] = 1'b0;
    tick();
    #2 rst_n[k] = 1'b0;
    #1;
    check($sformatf("arst_wen[%0d]", k), 32'(sram_wen[k]), 0);
    check($sformatf("arst_sense[%0d]", k), 32'(sram_sense_en[k]), 0);
    check($sformatf("arst_addr[%0d]", k), 32'(sram_addr[k]), 0);
    check($sformatf("arst_din[%0d]", k), 32'(sram_din[k]), 0);
    check($sformatf("arst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 0);
    check($sformatf("arst_rdata[%0d]", k), 32'(rsp_rdata[k]), 0);
    check($sformatf("arst_req_ready[%0d]", k), 32'(req_ready[k]), 1);
    repeat (2) @(posedge clk);
    #3 rst_n[k] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid[k]) seen = 1'b1;
    end
    check($sformatf("arst_no_rsp[%0d]", k), 32'(seen), 0);
    do_read(k, 10'h055, 0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
      rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_wen[%0d]", k), 32'(sram_wen[k]), 0);
      check($sformatf("rst_sense[%0d]", k), 32'(sram_sense_en[k]), 0);
      check($sformatf("rst_addr[%0d]", k), 32'(sram_addr[k]), 0);
      check($sformatf("rst_din[%0d]", k), 32'(sram_din[k]), 0);
      check($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 0);
      check($sformatf("rst_rdata[%0d]", k), 32'(rsp_rdata[k]), 0);
      check($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 1);
    end
    #2;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    tick();

    for (int k = 0; k < NI; k++) begin
      do_write(k, 10'h3FF, 8'hA5);
      do_read(k, 10'h3FF, 0);
      do_read(k, 10'h3FF, 5);

      for (int i = 0; i < 16; i++) begin
        int prev;
        prev = acc_cyc[k];
        do_write(k, 10'(i), 8'($urandom));
        if (i > 0) check($sformatf("b2b_gap[%0d]", k), 32'(acc_cyc[k] - prev), 2);
      end
      for (int i = 0; i < 16; i++) do_read(k, 10'(i), $urandom_range(0, 2));

      reset_during_wait(k);

      for (int i = 0; i < 32; i++) do_write(k, 10'(10'h200 + i), 8'($urandom));
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 1)
          do_write(k, 10'(10'h200 + $urandom_range(0, 31)), 8'($urandom));
        else
          do_read(k, 10'(10'h200 + $urandom_range(0, 31)), $urandom_range(0, 3));
      end
    end

    tick();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("wen_cycles[%0d]", k), 32'(wen_cycles[k]), 32'(exp_wen[k]));
      check($sformatf("sense_cycles[%0d]", k), 32'(sense_cycles[k]), 32'(exp_sense[k]));
      check($sformatf("strobe_overlap[%0d]", k), 32'(overlap_cyc[k]), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
